ped_request_conditioner: RTL and testbench
==========================================

Name: ped_request_conditioner

Overview:
- Upstream stage of the traffic-light controller; produces its pedestrian button input `bt`.
- Synchronises and debounces the raw pedestrian push-button, then latches a crossing request.
- Holds the request until the controller shows walk on its pedestrian lamp output B (3'b100).
- Applies a re-request lockout after each walk phase, and drives a "wait" indicator and a press counter.

Parameters:
- DB_CYCLES, 16: consecutive stable cycles needed to accept a button level change (1..511).
- LOCKOUT_CYCLES, 100: cycles after walk ends during which no new request is raised (1..511).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; asynchronous, active-low.
- btn_raw  input  1  raw push-button, asynchronous to clk, 1 = pressed.
- lamp_b  input  3  controller pedestrian lamp, one-hot: 001 = don't walk, 010 = clearing, 100 = walk.
- bt  output  1  request level to the controller; 1 = pedestrian waiting.
- wait_led  output  1  "WAIT" indicator; equal to bt.
- press_cnt  output  8  count of accepted presses, saturating.

Behaviour:
- Reset (rst=0, async):
  - sync flops, debounced level btn_db, debounce counter, lockout counter and pend flag all cleared.
  - state = IDLE; bt = 0, wait_led = 0, press_cnt = 0.
- Synchroniser: two flops on btn_raw. Only the second flop output (s2) is used downstream.
- Debounce (9-bit counter):
  - While s2 == btn_db: counter = 0.
  - Otherwise the counter increments each cycle.
  - When the counter reaches DB_CYCLES-1 with s2 still differing, btn_db takes s2 and the counter is cleared.
  - Net effect: btn_db follows btn_raw after 2 + DB_CYCLES cycles of stability. Glitches shorter than DB_CYCLES cycles are filtered.
- press: one-cycle internal pulse on a 0->1 transition of btn_db. Releases generate nothing.
- press_cnt: +1 on every press in any state; holds at 255.
- walk = (lamp_b == 3'b100). Any non-one-hot lamp_b value is treated as walk = 0.
- State machine (registered, 2 bits):
  - IDLE:
    - press && !walk -> PENDING.
    - press && walk -> stays IDLE (crossing already open; press counted only).
  - PENDING:
    - walk -> SERVING.
    - Further presses are counted only.
  - SERVING:
    - !walk -> LOCKOUT; lockout counter loaded with LOCKOUT_CYCLES-1; pend cleared.
    - Presses are counted only.
  - LOCKOUT:
    - Counter decrements each cycle.
    - A press sets pend.
    - At counter == 0: pend ? PENDING : IDLE, and pend is cleared.
    - Lockout duration is exactly LOCKOUT_CYCLES cycles.
  - Unused encoding -> IDLE on the next edge.
- Outputs:
  - bt = wait_led = (state == PENDING), decoded from the state register (glitch-free).
  - Latency: press pulse in cycle N -> bt = 1 from cycle N+1.
  - walk sampled in cycle M while PENDING -> bt = 0 from cycle M+1.
- Simultaneous events:
  - press and walk both asserting in PENDING: walk wins, go to SERVING.
  - press in the final LOCKOUT cycle: counts as pend and gives PENDING.
- Reset mid-operation: everything returns to reset values immediately. A button held through reset deasserting is accepted as a fresh press after 2 + DB_CYCLES cycles.

Test Plan:
1. Reset, btn_raw = 1 held steady, lamp_b = 001 -> press_cnt = 1 and bt rises 2+16 cycles after the edge (+1 for the FSM), then stays 1.
2. Bounce: btn_raw pulses high for 10 cycles, three times with 5-cycle gaps, lamp_b = 001 -> bt stays 0, press_cnt stays 0.
3. bt = 1, then lamp_b = 100 for 30 cycles, then 001 -> bt falls 1 cycle after lamp_b = 100. A debounced press 20 cycles into LOCKOUT gives bt = 1 exactly 100 cycles after walk ended. press_cnt increments on both presses.
4. No press during LOCKOUT -> state returns to IDLE after 100 cycles, bt = 0; a later press raises bt as in scenario 1.
5. Press while lamp_b = 100 from IDLE -> bt stays 0, press_cnt += 1. lamp_b = 011 (invalid) while PENDING -> bt stays 1.
6. 300 accepted presses -> press_cnt = 255. rst pulsed low mid-PENDING -> bt = 0 and press_cnt = 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ped_request_conditioner.sv
// Pedestrian request conditioner.
// Synchronises and debounces the raw push-button, latches a crossing request
// until the controller shows walk, then locks out new requests for a while.
// bt/wait_led come straight from the state register, so they never glitch.
module ped_request_conditioner #(
    parameter int DB_CYCLES      = 16,
    parameter int LOCKOUT_CYCLES = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_raw,
    input  logic [2:0] lamp_b,
    output logic       bt,
    output logic       wait_led,
    output logic [7:0] press_cnt
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] PENDING = 2'd1;
    localparam logic [1:0] SERVING = 2'd2;
    localparam logic [1:0] LOCKOUT = 2'd3;

    localparam logic [8:0] DB_LAST = 9'(DB_CYCLES - 1);
    localparam logic [8:0] LK_LOAD = 9'(LOCKOUT_CYCLES - 1);

    logic       s1, s2;
    logic       btn_db, db_q;
    logic [8:0] db_cnt;
    logic [8:0] lk_cnt;
    logic       pend;
    logic [1:0] state, state_nx;
    logic       press, walk;

    // Two-flop synchroniser; only s2 is used downstream.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= btn_raw;
            s2 <= s1;
        end
    end

    // Debounce: accept a new level only after DB_CYCLES consecutive differing cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_db <= 1'b0;
            db_cnt <= '0;
        end else if (s2 == btn_db) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            btn_db <= s2;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + 9'd1;
        end
    end

    // Delayed debounced level for rising-edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) db_q <= 1'b0;
        else      db_q <= btn_db;
    end

    assign press = btn_db & ~db_q;
    // Only a clean one-hot walk code counts; anything else is treated as not-walk.
    assign walk  = (lamp_b == 3'b100);

    // Saturating count of every accepted press, regardless of state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                         press_cnt <= '0;
        else if (press && press_cnt != 8'hFF) press_cnt <= press_cnt + 8'd1;
    end

    // Next-state decode.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (press && !walk) state_nx = PENDING;
            PENDING: if (walk)           state_nx = SERVING;
            SERVING: if (!walk)          state_nx = LOCKOUT;
            LOCKOUT: if (lk_cnt == '0)   state_nx = (pend || press) ? PENDING : IDLE;
            default:                     state_nx = IDLE;
        endcase
    end

    // State register plus lockout timer and the request remembered during lockout.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            lk_cnt <= '0;
            pend   <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                SERVING: if (!walk) begin
                    lk_cnt <= LK_LOAD;
                    pend   <= 1'b0;
                end
                LOCKOUT: begin
                    if (lk_cnt == '0) begin
                        pend <= 1'b0;
                    end else begin
                        lk_cnt <= lk_cnt - 9'd1;
                        if (press) pend <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bt       = (state == PENDING);
    assign wait_led = bt;

endmodule

// File: tb/tb_ped_request_conditioner.sv
// Bench for ped_request_conditioner: table of drive segments with expected bt,
// scoreboard queue of expected press_cnt values consumed when the count moves.
module tb_ped_request_conditioner;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_raw;
    logic [2:0] lamp_b;
    logic       bt, wait_led;
    logic [7:0] press_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int model_cnt = 0;
    logic [7:0] exp_q[$];
    logic [7:0] last_cnt = 8'd0;

    typedef struct {
        logic       btn;
        logic [2:0] lamp;
        int         n;
        logic       exp_bt;
        logic       press;
    } row_t;
    row_t tbl[$];

    ped_request_conditioner #(.DB_CYCLES(16), .LOCKOUT_CYCLES(100)) dut (
        .clk(clk), .rst(rst), .btn_raw(btn_raw), .lamp_b(lamp_b),
        .bt(bt), .wait_led(wait_led), .press_cnt(press_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic row(input logic b, input logic [2:0] l, input int n, input logic e, input logic p);
        row_t r;
        r.btn = b; r.lamp = l; r.n = n; r.exp_bt = e; r.press = p;
        tbl.push_back(r);
    endtask

    task automatic expect_press();
        if (model_cnt < 255) begin
            model_cnt++;
            exp_q.push_back(8'(model_cnt));
        end
    endtask

    // Scoreboard: each change of press_cnt consumes one expected value.
    always @(negedge clk) begin
        if (!rst) begin
            last_cnt = press_cnt;
        end else if (press_cnt !== last_cnt) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL press_cnt_unexpected: got %0d expected no change from %0d", press_cnt, last_cnt);
            end else begin
                chk("press_cnt_sb", press_cnt, exp_q.pop_front());
            end
            last_cnt = press_cnt;
        end
    end

    initial begin
        rst = 1'b0; btn_raw = 1'b0; lamp_b = 3'b001;
        #1;
        chk("reset_bt", bt, 0);
        chk("reset_wait", wait_led, 0);
        chk("reset_cnt", press_cnt, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Bounce: 10-cycle pulses separated by 5-cycle gaps must be rejected.
        for (int k = 0; k < 3; k++) begin
            btn_raw = 1'b1; repeat (10) @(negedge clk);
            btn_raw = 1'b0; repeat (5) @(negedge clk);
        end
        repeat (25) @(negedge clk);
        chk("bounce_bt", bt, 0);
        chk("bounce_cnt", press_cnt, 0);

        // Button held through reset release: fresh press after 2+16 cycles, +1 for FSM.
        row(1, 3'b001, 18, 0, 1);
        row(1, 3'b001, 1,  1, 0);
        row(1, 3'b001, 10, 1, 0);
        row(0, 3'b001, 25, 1, 0);
        // Walk served, then a press during lockout re-raises bt exactly 100 cycles later.
        row(0, 3'b100, 1,  0, 0);
        row(0, 3'b100, 29, 0, 0);
        row(0, 3'b001, 1,  0, 0);
        row(1, 3'b001, 20, 0, 1);
        row(1, 3'b001, 79, 0, 0);
        row(1, 3'b001, 1,  1, 0);
        row(0, 3'b001, 25, 1, 0);
        // Lockout with no press returns to idle; a later press works normally.
        row(0, 3'b100, 10, 0, 0);
        row(0, 3'b001, 100, 0, 0);
        row(0, 3'b001, 1,  0, 0);
        row(0, 3'b001, 30, 0, 0);
        row(1, 3'b001, 18, 0, 1);
        row(1, 3'b001, 1,  1, 0);
        row(0, 3'b001, 25, 1, 0);
        // Press during walk from idle is counted only; invalid lamp code is not walk.
        row(0, 3'b100, 5,  0, 0);
        row(0, 3'b001, 101, 0, 0);
        row(1, 3'b100, 19, 0, 1);
        row(1, 3'b100, 5,  0, 0);
        row(0, 3'b100, 25, 0, 0);
        row(1, 3'b001, 18, 0, 1);
        row(1, 3'b001, 1,  1, 0);
        row(0, 3'b011, 10, 1, 0);
        row(0, 3'b010, 20, 1, 0);
        row(0, 3'b001, 10, 1, 0);

        @(negedge clk);
        rst = 1'b0; btn_raw = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        model_cnt = 0;
        for (int i = 0; i < tbl.size(); i++) begin
            btn_raw = tbl[i].btn;
            lamp_b  = tbl[i].lamp;
            if (tbl[i].press) expect_press();
            repeat (tbl[i].n) @(negedge clk);
            chk($sformatf("row%0d_bt", i), bt, tbl[i].exp_bt);
            chk($sformatf("row%0d_wait", i), wait_led, tbl[i].exp_bt);
        end

        // Saturation: 300 clean presses while pending.
        lamp_b = 3'b001;
        for (int k = 0; k < 300; k++) begin
            btn_raw = 1'b1; expect_press();
            repeat (19) @(negedge clk);
            btn_raw = 1'b0;
            repeat (19) @(negedge clk);
        end
        chk("sat_cnt", press_cnt, 255);
        chk("sat_bt", bt, 1);
        chk("sb_drained", exp_q.size(), 0);

        // Asynchronous reset mid-pending takes effect without a clock edge.
        #2 rst = 1'b0;
        #1;
        chk("async_rst_bt", bt, 0);
        chk("async_rst_wait", wait_led, 0);
        chk("async_rst_cnt", press_cnt, 0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
